// File: rtl/dff_ram_ctrl.sv
// Parametrised flip-flop RAM with request/valid access, a one-word-per-cycle clear sweep
// and optional per-word even parity (enabled by defining DFF_RAM_PARITY_EN).
module dff_ram_ctrl #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              clr,
    input  logic              perr_inj,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              busy,
    output logic              parity_err
);

    // state  | meaning
    // SWEEP  | writing zero to mem[ptr] each cycle, accesses dropped, busy=1
    // READY  | accesses accepted, busy=0
    localparam logic [0:0] S_READY = 1'b0;
    localparam logic [0:0] S_SWEEP = 1'b1;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam bit                POW2     = (DEPTH == (1 << ADDR_W));

    logic [0:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              in_range;
    logic              acc;
    logic              wr_acc;
    logic              rd_acc;
    logic              sweep_wr;

    // Out-of-range addresses only exist when DEPTH is not a power of two.
    generate
        if (POW2) begin : g_full_range
            assign in_range = 1'b1;
        end else begin : g_part_range
            localparam logic [ADDR_W:0] DEPTH_X = ADDR_W'(DEPTH) + (ADDR_W+1)'(0);
            assign in_range = ({1'b0, addr} < DEPTH_X);
        end
    endgenerate

    assign acc      = (state == S_READY) && req && !clr;
    assign wr_acc   = acc && we && in_range;
    assign rd_acc   = acc && !we;
    assign sweep_wr = (state == S_SWEEP) && !clr;
    assign busy     = (state == S_SWEEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_SWEEP;
            ptr   <= '0;
        end else if (clr) begin
            state <= S_SWEEP;
            ptr   <= '0;
        end else if (state == S_SWEEP) begin
            if (ptr == LAST_PTR) begin
                state <= S_READY;
                ptr   <= '0;
            end else begin
                ptr <= ptr + 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset; the sweep provides the clearing.
    always_ff @(posedge clk) begin
        if (sweep_wr) begin
            mem[ptr] <= '0;
        end else if (wr_acc) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_acc;
            if (rd_acc) begin
                rdata <= in_range ? mem[addr] : '0;
            end
        end
    end

`ifdef DFF_RAM_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (sweep_wr) begin
            par_mem[ptr] <= 1'b0;
        end else if (wr_acc) begin
            par_mem[addr] <= (^wdata) ^ perr_inj;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else if (rd_acc) begin
            parity_err <= in_range && ((^mem[addr]) != par_mem[addr]);
        end
    end
`else
    logic unused_perr_inj;
    assign unused_perr_inj = perr_inj;
    assign parity_err      = 1'b0;
`endif

endmodule

// File: tb/tb_dff_ram_ctrl.sv
// Self-checking bench for dff_ram_ctrl: a 16-word instance for most features and a
// 10-word instance for out-of-range addressing; read expectations flow through a queue.
module tb_dff_ram_ctrl;

`ifdef DFF_RAM_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] d;
        logic       p;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       req, we, clr, perr_inj;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rvalid, busy, parity_err;

    logic       req10, we10, clr10, perr_inj10;
    logic [3:0] addr10;
    logic [7:0] wdata10;
    logic [7:0] rdata10;
    logic       rvalid10, busy10, parity_err10;

    exp_t       q[$];
    exp_t       e;
    logic [7:0] m16 [16];
    logic       p16 [16];
    int         n_pass;
    int         n_total;

    dff_ram_ctrl #(.DATA_W(8), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .clr(clr), .perr_inj(perr_inj), .rdata(rdata), .rvalid(rvalid), .busy(busy),
        .parity_err(parity_err)
    );

    dff_ram_ctrl #(.DATA_W(8), .DEPTH(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .req(req10), .we(we10), .addr(addr10), .wdata(wdata10),
        .clr(clr10), .perr_inj(perr_inj10), .rdata(rdata10), .rvalid(rvalid10), .busy(busy10),
        .parity_err(parity_err10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic r, input logic w, input logic [3:0] a, input logic [7:0] d,
                        input logic c, input logic pe);
        req = r; we = w; addr = a; wdata = d; clr = c; perr_inj = pe;
        @(negedge clk);
    endtask

    task automatic step10(input logic r, input logic w, input logic [3:0] a, input logic [7:0] d);
        req10 = r; we10 = w; addr10 = a; wdata10 = d; clr10 = 1'b0; perr_inj10 = 1'b0;
        @(negedge clk);
        req10 = 1'b0; we10 = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) begin
            m16[i] = 8'h00;
            p16[i] = 1'b0;
        end
    endtask

    task automatic wr16(input logic [3:0] a, input logic [7:0] d, input logic pe);
        step(1'b1, 1'b1, a, d, 1'b0, pe);
        m16[a] = d;
        p16[a] = (^d) ^ pe;
    endtask

    task automatic rd16(input logic [3:0] a);
        exp_t x;
        x.d = m16[a];
        x.p = PAR_EN ? ((^m16[a]) ^ p16[a]) : 1'b0;
        q.push_back(x);
        step(1'b1, 1'b0, a, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic pop_exp();
        if (q.size() == 0) begin
            e.d = 8'hxx;
            e.p = 1'bx;
        end else begin
            e = q.pop_front();
        end
    endtask

    task automatic count_busy(input string name, input int expected);
        int cnt = 0;
        int g   = 0;
        while (busy === 1'b1 && g < 100) begin
            cnt++;
            g++;
            idle();
        end
        n_total++;
        if (g >= 100 || cnt != expected)
            $display("FAIL %s: busy cycles=%0d expected=%0d", name, cnt, expected);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        idle();
        n_total++;
        if (busy !== 1'b1 || rvalid !== 1'b0 || rdata !== 8'h00 || parity_err !== 1'b0)
            $display("FAIL reset_values: busy=%b rvalid=%b rdata=%h perr=%b expected 1 0 00 0",
                     busy, rvalid, rdata, parity_err);
        else
            n_pass++;
        rst_n = 1'b1;
        count_busy("reset_busy_window", 16);
        clear_model();
        for (int i = 0; i < 16; i++) begin
            rd16(4'(i));
            pop_exp();
            n_total++;
            if (rvalid !== 1'b1 || rdata !== e.d || parity_err !== e.p)
                $display("FAIL post_reset_read[%0d]: rdata=%h rvalid=%b perr=%b expected rdata=%h rvalid=1 perr=%b",
                         i, rdata, rvalid, parity_err, e.d, e.p);
            else
                n_pass++;
        end
        idle();
        n_total++;
        if (rvalid !== 1'b0)
            $display("FAIL rvalid_single_pulse: rvalid=%b expected 0", rvalid);
        else
            n_pass++;
    endtask

    task automatic test_write_read();
        logic [3:0] seq [3];
        seq[0] = 4'd3; seq[1] = 4'd15; seq[2] = 4'd3;
        wr16(4'd3, 8'hA5, 1'b0);
        n_total++;
        if (rvalid !== 1'b0)
            $display("FAIL write_no_rvalid: rvalid=%b expected 0", rvalid);
        else
            n_pass++;
        wr16(4'd15, 8'h5A, 1'b0);
        for (int i = 0; i < 3; i++) begin
            rd16(seq[i]);
            pop_exp();
            n_total++;
            if (rvalid !== 1'b1 || rdata !== e.d)
                $display("FAIL write_read[%0d]: rdata=%h rvalid=%b expected rdata=%h rvalid=1",
                         i, rdata, rvalid, e.d);
            else
                n_pass++;
        end
        idle();
        n_total++;
        if (rvalid !== 1'b0 || rdata !== 8'hA5)
            $display("FAIL rdata_hold: rdata=%h rvalid=%b expected rdata=a5 rvalid=0", rdata, rvalid);
        else
            n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [2];
        vals[0] = 8'hC3; vals[1] = 8'h3D;
        for (int i = 0; i < 2; i++) begin
            wr16(4'd7, vals[i], 1'b0);
            rd16(4'd7);
            pop_exp();
            n_total++;
            if (rvalid !== 1'b1 || rdata !== e.d)
                $display("FAIL back_to_back[%0d]: rdata=%h rvalid=%b expected rdata=%h rvalid=1",
                         i, rdata, rvalid, e.d);
            else
                n_pass++;
        end
    endtask

    task automatic test_parity();
        logic [3:0] pa [3];
        logic [7:0] pd [3];
        logic       pi [3];
        pa[0] = 4'd4;  pd[0] = 8'h3C; pi[0] = 1'b1;
        pa[1] = 4'd4;  pd[1] = 8'h3C; pi[1] = 1'b0;
        pa[2] = 4'd11; pd[2] = 8'h07; pi[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr16(pa[i], pd[i], pi[i]);
            rd16(pa[i]);
            pop_exp();
            n_total++;
            if (rvalid !== 1'b1 || rdata !== e.d || parity_err !== e.p)
                $display("FAIL parity[%0d]: rdata=%h perr=%b expected rdata=%h perr=%b",
                         i, rdata, parity_err, e.d, e.p);
            else
                n_pass++;
        end
    endtask

    task automatic test_non_pow2();
        exp_t x;
        step10(1'b1, 1'b1, 4'd2, 8'h11);
        step10(1'b1, 1'b1, 4'd12, 8'h77);
        x.d = 8'h00; x.p = 1'b0;
        q.push_back(x);
        step10(1'b1, 1'b0, 4'd12, 8'h00);
        pop_exp();
        n_total++;
        if (rvalid10 !== 1'b1 || rdata10 !== e.d || parity_err10 !== e.p)
            $display("FAIL oob_read: rdata=%h rvalid=%b perr=%b expected rdata=%h rvalid=1 perr=%b",
                     rdata10, rvalid10, parity_err10, e.d, e.p);
        else
            n_pass++;
        x.d = 8'h11; x.p = 1'b0;
        q.push_back(x);
        step10(1'b1, 1'b0, 4'd2, 8'h00);
        pop_exp();
        n_total++;
        if (rvalid10 !== 1'b1 || rdata10 !== e.d)
            $display("FAIL oob_neighbour: rdata=%h rvalid=%b expected rdata=%h rvalid=1",
                     rdata10, rvalid10, e.d);
        else
            n_pass++;
    endtask

    task automatic test_clr();
        int cnt;
        int g;
        wr16(4'd0, 8'h33, 1'b0);
        wr16(4'd5, 8'h55, 1'b0);
        step(1'b1, 1'b1, 4'd0, 8'hFF, 1'b1, 1'b0);
        n_total++;
        if (busy !== 1'b1)
            $display("FAIL clr_busy: busy=%b expected 1", busy);
        else
            n_pass++;
        cnt = 1;
        idle();
        cnt += int'(busy);
        step(1'b1, 1'b0, 4'd5, 8'h00, 1'b0, 1'b0);
        cnt += int'(busy);
        n_total++;
        if (rvalid !== 1'b0)
            $display("FAIL sweep_read_dropped: rvalid=%b expected 0", rvalid);
        else
            n_pass++;
        idle();
        cnt += int'(busy);
        idle();
        cnt += int'(busy);
        step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
        cnt += int'(busy);
        g = 0;
        while (busy === 1'b1 && g < 100) begin
            idle();
            cnt += int'(busy);
            g++;
        end
        n_total++;
        if (g >= 100 || cnt != 21)
            $display("FAIL clr_restart_busy: busy cycles=%0d expected=21", cnt);
        else
            n_pass++;
        clear_model();
        rd16(4'd0);
        pop_exp();
        n_total++;
        if (rvalid !== 1'b1 || rdata !== e.d)
            $display("FAIL clr_addr0: rdata=%h rvalid=%b expected rdata=%h rvalid=1", rdata, rvalid, e.d);
        else
            n_pass++;
        rd16(4'd5);
        pop_exp();
        n_total++;
        if (rvalid !== 1'b1 || rdata !== e.d)
            $display("FAIL clr_addr5: rdata=%h rvalid=%b expected rdata=%h rvalid=1", rdata, rvalid, e.d);
        else
            n_pass++;
    endtask

    task automatic test_reset_mid_read();
        exp_t x;
        wr16(4'd9, 8'h42, 1'b0);
        x.d = m16[9]; x.p = 1'b0;
        q.push_back(x);
        req = 1'b1; we = 1'b0; addr = 4'd9;
        @(posedge clk);
        #1;
        req = 1'b0;
        pop_exp();
        n_total++;
        if (rvalid !== 1'b1 || rdata !== e.d)
            $display("FAIL mid_read_accept: rdata=%h rvalid=%b expected rdata=%h rvalid=1", rdata, rvalid, e.d);
        else
            n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (rvalid !== 1'b0 || rdata !== 8'h00 || busy !== 1'b1)
            $display("FAIL async_reset: rvalid=%b rdata=%h busy=%b expected 0 00 1", rvalid, rdata, busy);
        else
            n_pass++;
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        count_busy("reset_mid_busy_window", 16);
        clear_model();
        rd16(4'd9);
        pop_exp();
        n_total++;
        if (rvalid !== 1'b1 || rdata !== e.d)
            $display("FAIL after_reset_read: rdata=%h rvalid=%b expected rdata=%h rvalid=1", rdata, rvalid, e.d);
        else
            n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst_n = 1'b0;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0; clr = 1'b0; perr_inj = 1'b0;
        req10 = 1'b0; we10 = 1'b0; addr10 = '0; wdata10 = '0; clr10 = 1'b0; perr_inj10 = 1'b0;
        clear_model();
        test_reset();
        test_write_read();
        test_back_to_back();
        test_parity();
        test_non_pow2();
        test_clr();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dff_ram_ctrl.md
# dff_ram_ctrl

Parametrised flip-flop RAM with a request/valid access interface, a self-clearing sweep engine and optional per-word parity. It replaces the fixed 16×8 DFF memory used in tile-level designs: width and depth are generic, clearing is done one word per cycle instead of resetting every storage bit, and reads carry a valid strobe. It sits directly behind the tile's pin-decode logic, or any small on-chip master, as local scratch storage.

## Interface
- `DATA_W`, default 8: data word width in bits, range 1 to 32.
- `DEPTH`, default 16: number of words, range 2 to 64, need not be a power of two.
- `ADDR_W`, default `$clog2(DEPTH)`: address width, derived; do not override.

- `clk` in 1: the single clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req` in 1: access request, sampled every cycle.
- `we` in 1: with `req` high, 1 selects a write and 0 selects a read.
- `addr` in `ADDR_W`: word address.
- `wdata` in `DATA_W`: write data.
- `clr` in 1: single-cycle pulse that starts a clear sweep.
- `perr_inj` in 1: with a write, stores inverted parity. Ignored without parity.
- `rdata` out `DATA_W`: registered read data.
- `rvalid` out 1: `rdata` is valid this cycle.
- `busy` out 1: clear sweep in progress; requests are not accepted.
- `parity_err` out 1: parity mismatch on the current `rdata`. Qualified by `rvalid`.

## Operation
- **FSM states**
  - SWEEP: `busy`=1. A pointer `ptr` writes zero (parity 0) to `RAM[ptr]` each cycle, then `ptr` increments.
  - When `ptr`==`DEPTH-1`, that word is written and the next state is READY.
  - READY: `busy`=0. Accesses are accepted.
- **Transitions**
  - Reset enters SWEEP with `ptr`=0, so the first sweep follows reset.
  - A `clr` pulse in READY enters SWEEP with `ptr`=0.
  - A `clr` pulse in SWEEP restarts the sweep at `ptr`=0.
- **Accepted access:** `req`=1 and state READY and `clr`=0.
  - If `clr` and `req` are both high in READY, `clr` wins and the request is dropped with no write and no `rvalid`.
- **Requests outside READY:** `req` in SWEEP is dropped silently. There is no queueing and no back-pressure other than `busy`.
- **Write:** `RAM[addr]` is loaded with `wdata` at the clock edge. No `rvalid` is produced.
- **Read:** `rdata` is loaded with `RAM[addr]` at the edge and `rvalid` pulses high for 1 cycle.
  - `rdata` holds its last value when no read is accepted.
- **Out-of-range address** (`addr` >= `DEPTH`, possible only when `DEPTH` is not a power of two):
  - A write is discarded.
  - A read returns all zeros with `rvalid`=1 and `parity_err`=0.
- **Back-to-back accesses:** a read may be accepted every cycle. A write followed by a read of the same address returns the new data.
- **Storage reset:** the storage array is never reset by `rst_n`. Only the FSM, `ptr`, `rdata`, `rvalid` and `parity_err` are reset.

## Timing
- **Reset values**
  - `rdata`=0, `rvalid`=0, `parity_err`=0.
  - `busy`=1 immediately and asynchronously on `rst_n` low.
- **Busy window after reset:** `busy` stays high for exactly `DEPTH` cycles after the first rising edge with `rst_n` high.
- **Sweep after `clr`:** `clr` sampled at edge N gives `busy`=1 from after edge N, and READY after edge N+`DEPTH`.
- **Read latency:** 1 cycle. A request at edge N gives `rdata`/`rvalid` valid after edge N until edge N+1.
- **Reset mid-operation:** the sweep aborts, any pending `rvalid` is cleared, and a full sweep restarts after release.
- **Output registers:** `busy` is a decoded state register. `rvalid` and `rdata` are registered. No output is combinational from inputs.

## Configuration
- **Macro `DFF_RAM_PARITY_EN`**
  - **Defined:** each word stores an extra even-parity bit. On a write the stored bit is the XOR of `wdata`, inverted when `perr_inj`=1. On a read, `parity_err` is registered alongside `rdata` and is 1 when the recomputed parity differs from the stored bit. The sweep stores parity 0.
  - **Undefined:** there is no parity storage, `parity_err` is tied to 0 and `perr_inj` is unused. The storage cost is `DEPTH`×`DATA_W` flops.

## Test plan
- **Post-reset clear:** release reset with DATA_W=8 and DEPTH=16 → `busy`=1 for 16 cycles. Then reading every address returns 0x00 with `rvalid` pulsing once per read.
- **Write/read:** write 0xA5 to address 3 and 0x5A to address 15, then read addresses 3, 15, 3 on consecutive cycles → `rdata` = 0xA5, 0x5A, 0xA5 on consecutive cycles with `rvalid` held high.
- **`clr` collision and restart:**
  - Assert `clr` and a write of 0xFF to address 0 in the same cycle → the write is dropped.
  - Pulse `clr` again 5 cycles into the sweep → `busy` lasts 5+16 cycles in total, then address 0 reads 0x00.
- **Non-power-of-two depth:** with DEPTH=10, write 0x77 to address 12, then read address 12 → `rdata`=0x00 and `rvalid`=1. Address 2 is unchanged.
- **Parity (`DFF_RAM_PARITY_EN` defined):**
  - Write 0x3C to address 4 with `perr_inj`=1, then read → `rdata`=0x3C and `parity_err`=1.
  - Rewrite with `perr_inj`=0, then read → `parity_err`=0.
- **Reset mid-read:** accept a read, then drop `rst_n` low asynchronously before the next edge → `rvalid`=0 and `rdata`=0 at once, and `busy`=1 until a full 16-cycle sweep completes.
